ts_cc_monitor: RTL
==================

# ts_cc_monitor

Multi-PID MPEG-2 TS continuity-counter monitor on the byte-serial transport stream path. Parses the 4-byte TS header of each packet, matches the PID against `NUM_CH` programmable PID slots, checks the 4-bit continuity_counter against ISO/IEC 13818-1 rules, and keeps a saturating per-channel error count plus a global total. It is the parametrised, multi-channel replacement for the single-stream packet-loss counter in the QoS control chain.

## Interface
- `NUM_CH`, 4: number of monitored PID slots (1..16).
- `CNT_W`, 16: width of each error counter.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sync`  in  1  marks byte 0 of a packet; qualified by `valid`.
- `valid`  in  1  `data` byte valid this cycle.
- `data`  in  8  TS byte stream.
- `clr`  in  1  synchronous clear of all counters and per-channel history.
- `ch_en`  in  NUM_CH  per-slot enable.
- `pid_cfg`  in  NUM_CH*13  slot i PID at bits [13i+12:13i].
- `err_count`  out  NUM_CH*CNT_W  slot i counter at [CNT_W*i+:CNT_W].
- `err_total`  out  CNT_W  sum of all CC errors, saturating.
- `err_pulse`  out  1  one-cycle strobe per detected CC error.
- `err_ch`  out  $clog2(NUM_CH) (min 1)  slot of last error; held until next error.

## Operation
- FSM: IDLE, HDR1, HDR2, HDR3, CHECK, SKIP. Advances only on `valid` bytes, except CHECK (one unconditional cycle).
- IDLE/SKIP: `valid&&sync&&data==8'h47` -> HDR1; `valid&&sync` with other byte -> SKIP (packet dropped).
- HDR1: capture TEI=data[7], PID[12:8]=data[4:0]. HDR2: PID[7:0]. HDR3: AFC=data[5:4], CC=data[3:0] -> CHECK.
- `valid&&sync` in any HDRx state aborts the current header and restarts parse as byte 0 (resync).
- CHECK: packet ignored (no state change) if TEI=1, PID=13'h1FFF, or AFC=2'b00. Otherwise slot match = lowest index i with `ch_en[i]` and `pid_cfg` slot == PID; no match -> ignored.
- Per slot history: `seen`, `last_cc[3:0]`, `dup`.
- First packet with `seen=0`: load `last_cc`, set `seen`, no error.
- Payload present (AFC[0]=1): expected = `last_cc+1` mod 16. No payload (AFC=2'b10): expected = `last_cc`.
- Match -> `last_cc<=CC`, `dup<=0`. Mismatch -> error: slot counter +1, `err_total` +1 (both saturate at all-ones), `err_pulse`, `err_ch<=i`, `last_cc<=CC` (resync), `dup<=0`.
- Duplicate handling per Configuration.
- CHECK -> SKIP; if `valid&&sync&&data==8'h47` in the CHECK cycle, go to HDR1 directly (byte not lost).
- `ch_en[i]` low clears slot i `seen`/`dup`; counter retained. `pid_cfg` slot is static while enabled.
- `clr`: zeroes all counters, `seen`, `dup`; overrides a coincident error update.

## Timing
- Reset: state IDLE, `err_count`=0, `err_total`=0, `err_pulse`=0, `err_ch`=0, all `seen`/`dup`/`last_cc`=0.
- Byte 3 accepted at edge k -> counters updated and `err_pulse` high after edge k+1, for exactly one cycle.
- Back-to-back packets with no gap supported (byte 0 of next packet arrives in CHECK cycle).
- Reset mid-packet: immediate return to reset values; parse resumes on next valid sync.

## Configuration
- `TS_CC_DUP_TOLERANCE_EN` defined: payload packet with CC==`last_cc` and `dup=0` is a legal duplicate; set `dup`, no error, `last_cc` unchanged. Second consecutive duplicate is an error.
- Undefined: any payload packet with CC==`last_cc` is an error; `dup` logic absent.

## Structure
- Package `ts_pkg`: `TS_SYNC_BYTE`=8'h47, `TS_NULL_PID`=13'h1FFF, `TS_PID_W`=13, AFC encodings, FSM state enum.
- Sub-module `ts_hdr_parser`: FSM IDLE..HDR3 plus resync, outputs a one-cycle `hdr_valid` with TEI/PID/AFC/CC. Top instantiates it and holds the slot table and counters.

## Test plan
- Slot0 PID 0x100, CC 0,1,2,3 with AFC=01 -> `err_count[0]`=0, no `err_pulse`.
- PID 0x100 CC 5 then 7 -> one `err_pulse` 2 cycles after byte 3, `err_ch`=0, count=1; following CC 8 -> no error.
- CC 15 then 0 (wrap) -> no error; AFC=10 with CC unchanged -> no error; AFC=10 with CC+1 -> error.
- CC 4,4 -> no error with `TS_CC_DUP_TOLERANCE_EN`, 1 error without; CC 4,4,4 -> 1 error with macro.
- TEI=1, PID 0x1FFF, unmatched PID, AFC=00, or byte0=0x48 with sync -> counters unchanged.
- Force count to all-ones then error -> holds saturated; `clr` coincident with error -> counts 0; sync mid-header -> clean reparse.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared constants, header record and parse-state encoding for the TS continuity-counter monitor.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PID_W     = 13;
  localparam logic [TS_PID_W-1:0] TS_NULL_PID = 13'h1FFF;

  localparam logic [1:0] AFC_RESERVED = 2'b00;
  localparam logic [1:0] AFC_PAYLOAD  = 2'b01;
  localparam logic [1:0] AFC_ADAPT    = 2'b10;
  localparam logic [1:0] AFC_BOTH     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_CHECK,
    ST_SKIP
  } ts_state_e;

  typedef struct packed {
    logic                tei;
    logic [TS_PID_W-1:0] pid;
    logic [1:0]          afc;
    logic [3:0]          cc;
  } ts_hdr_t;

  function automatic logic afc_has_payload(input logic [1:0] afc);
    return (afc == AFC_PAYLOAD) || (afc == AFC_BOTH);
  endfunction

  // Adaptation-only packets must repeat the counter; payload packets advance it.
  function automatic logic [3:0] cc_expected(input logic [3:0] last_cc, input logic [1:0] afc);
    logic [3:0] nxt;
    case (afc)
      AFC_PAYLOAD, AFC_BOTH: nxt = last_cc + 4'd1;
      AFC_ADAPT:             nxt = last_cc;
      default:               nxt = last_cc;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ts_cc_monitor_if.sv
// Byte-serial transport stream bus: sync marks byte 0, valid qualifies data and sync.
interface ts_cc_monitor_if;
  logic       sync;
  logic       valid;
  logic [7:0] data;

  modport master (output sync, output valid, output data);
  modport slave  (input sync, input valid, input data);
endinterface

// File: rtl/ts_hdr_parser.sv
// TS header parser: walks bytes 0..3 of each packet and presents the header for one CHECK cycle.
//   state | meaning
//   IDLE  | after reset, waiting for a valid sync byte
//   HDR1  | byte 0 seen; next byte carries TEI and PID[12:8]
//   HDR2  | next byte carries PID[7:0]
//   HDR3  | next byte carries AFC and CC
//   CHECK | header complete, hdr_valid high for one cycle
//   SKIP  | rest of packet (or dropped packet), waiting for sync
module ts_hdr_parser
  import ts_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ts_cc_monitor_if.slave stream,
  output logic           hdr_valid,
  output ts_hdr_t        hdr
);

  ts_state_e state, state_nx;
  ts_state_e sync_target;
  logic      is_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    is_start    = stream.valid && stream.sync && (stream.data == TS_SYNC_BYTE);
    sync_target = is_start ? ST_HDR1 : ST_SKIP;
    state_nx    = state;
    hdr_valid   = 1'b0;
    case (state)
      ST_IDLE, ST_SKIP: if (stream.valid && stream.sync) state_nx = sync_target;
      ST_HDR1:          if (stream.valid) state_nx = stream.sync ? sync_target : ST_HDR2;
      ST_HDR2:          if (stream.valid) state_nx = stream.sync ? sync_target : ST_HDR3;
      ST_HDR3:          if (stream.valid) state_nx = stream.sync ? sync_target : ST_CHECK;
      ST_CHECK: begin
        // Unconditional: a packet starting right behind this one must not be lost.
        hdr_valid = 1'b1;
        state_nx  = is_start ? ST_HDR1 : ST_SKIP;
      end
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr <= '0;
    end else if (stream.valid && !stream.sync) begin
      case (state)
        ST_HDR1: begin
          hdr.tei       <= stream.data[7];
          hdr.pid[12:8] <= stream.data[4:0];
        end
        ST_HDR2: hdr.pid[7:0] <= stream.data;
        ST_HDR3: begin
          hdr.afc <= stream.data[5:4];
          hdr.cc  <= stream.data[3:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ts_cc_monitor.sv
// Multi-PID continuity-counter monitor: PID slot table, CC history and saturating error counters.
// Build option TS_CC_DUP_TOLERANCE_EN accepts one duplicate payload packet per slot.
module ts_cc_monitor
  import ts_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  ts_cc_monitor_if.slave             stream,
  input  logic                       clr,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH*TS_PID_W-1:0] pid_cfg,
  output logic [NUM_CH*CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]           err_total,
  output logic                       err_pulse,
  output logic [CH_W-1:0]            err_ch
);

  logic       hdr_valid;
  ts_hdr_t    hdr;

  logic [NUM_CH-1:0] seen;
  logic [3:0]        last_cc [NUM_CH];
  logic [CNT_W-1:0]  cnt     [NUM_CH];
`ifdef TS_CC_DUP_TOLERANCE_EN
  logic [NUM_CH-1:0] dup;
`endif

  logic            hit, act, dup_ok, cc_err;
  logic [CH_W-1:0] idx;

  ts_hdr_parser u_parser (
    .clk       (clk),
    .rst       (rst),
    .stream    (stream),
    .hdr_valid (hdr_valid),
    .hdr       (hdr)
  );

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Descending scan so the lowest matching slot wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i] && (pid_cfg[TS_PID_W*i +: TS_PID_W] == hdr.pid)) begin
        hit = 1'b1;
        idx = CH_W'(i);
      end
    end
    act = hdr_valid && hit && !hdr.tei && (hdr.pid != TS_NULL_PID) && (hdr.afc != AFC_RESERVED);
`ifdef TS_CC_DUP_TOLERANCE_EN
    dup_ok = act && seen[idx] && afc_has_payload(hdr.afc) && (hdr.cc == last_cc[idx]) && !dup[idx];
`else
    dup_ok = 1'b0;
`endif
    cc_err = act && seen[idx] && !dup_ok && (hdr.cc != cc_expected(last_cc[idx], hdr.afc));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen      <= '0;
      err_total <= '0;
      err_pulse <= 1'b0;
      err_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        last_cc[i] <= '0;
        cnt[i]     <= '0;
      end
`ifdef TS_CC_DUP_TOLERANCE_EN
      dup <= '0;
`endif
    end else if (clr) begin
      seen      <= '0;
      err_total <= '0;
      err_pulse <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
`ifdef TS_CC_DUP_TOLERANCE_EN
      dup <= '0;
`endif
    end else begin
      err_pulse <= cc_err;
      seen      <= seen & ch_en;
`ifdef TS_CC_DUP_TOLERANCE_EN
      dup       <= dup & ch_en;
`endif
      if (act) begin
        if (!seen[idx]) begin
          seen[idx]    <= 1'b1;
          last_cc[idx] <= hdr.cc;
`ifdef TS_CC_DUP_TOLERANCE_EN
          dup[idx]     <= 1'b0;
        end else if (dup_ok) begin
          dup[idx]     <= 1'b1;
`endif
        end else begin
          last_cc[idx] <= hdr.cc;
`ifdef TS_CC_DUP_TOLERANCE_EN
          dup[idx]     <= 1'b0;
`endif
          if (cc_err) begin
            err_ch <= idx;
            if (cnt[idx] != '1)  cnt[idx]  <= cnt[idx] + 1'b1;
            if (err_total != '1) err_total <= err_total + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    err_count = '0;
    for (int i = 0; i < NUM_CH; i++) err_count[CNT_W*i +: CNT_W] = cnt[i];
  end

endmodule
